column_window_buffer: RTL
=========================

// Module: column_window_buffer
// PURPOSE
//  Upstream feeder for the Y-moment stage.
//  - Takes a raster luma stream, one pixel per accepted cycle, with no backpressure.
//  - Buffers WINDOW_SIZE_Y-1 previous lines and emits one vertical column of WINDOW_SIZE_Y pixels per input pixel.
//  - Also emits the column WINDOW_SIZE_X valid columns older (the peek column) and a per-row reset pulse.
//  - Outputs connect 1:1 to the moment stage's in_column/in_peek_column/in_valid/in_reset.
// PARAMETERS
//  LUMA_BITS      8    bits per pixel
//  WINDOW_SIZE_X  31   window width (odd); peek-column delay in valid columns
//  WINDOW_SIZE_Y  31   window height (odd); column length
//  IMAGE_WIDTH    640  max pixels per line; sets line-buffer depth
// PORTS
//  clk              in   1                        single clock, rising edge
//  reset_n          in   1                        asynchronous, active-low
//  in_valid         in   1                        in_pixel valid this cycle
//  in_line_start    in   1                        qualifies first pixel of a line (with in_valid)
//  in_frame_start   in   1                        qualifies first pixel of a frame (implies line start)
//  in_pixel         in   LUMA_BITS                luma sample
//  out_valid        out  1                        out_column/out_peek_column valid
//  out_row_reset    out  1                        first valid column of a row (drives moment-stage in_reset)
//  out_column       out  LUMA_BITS x WINDOW_SIZE_Y [0]=oldest/top row ... [Y-1]=current row
//  out_peek_column  out  LUMA_BITS x WINDOW_SIZE_Y out_column from WINDOW_SIZE_X valid columns earlier
//  out_overrun      out  1                        sticky: a pixel arrived with x >= IMAGE_WIDTH
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - All outputs 0; x=0; rows_filled=0; peek shift register cleared; out_overrun cleared.
//   - Line-buffer RAM contents are not cleared.
//  Counters:
//   - x is the column index, width clog2(IMAGE_WIDTH+1).
//   - rows_filled counts completed lines in the frame; it saturates at WINDOW_SIZE_Y-1.
//  Input accept (in_valid=1):
//   - in_frame_start: x<=1; rows_filled<=0; this pixel is column 0 of a new frame.
//   - else in_line_start: x<=1; rows_filled<=min(rows_filled+1, Y-1) if the previous line had x!=0, else unchanged.
//   - else, x<IMAGE_WIDTH: x<=x+1.
//   - else (x==IMAGE_WIDTH): pixel dropped, out_overrun<=1, no output for that pixel.
//  Line buffers:
//   - Cascade of Y-1 buffers, each IMAGE_WIDTH deep, addressed by the effective column cx (0 on line/frame start, else x).
//   - Per accepted pixel: read lb[k][cx] for all k, then write lb[0][cx]<=in_pixel and lb[k+1][cx]<=old lb[k][cx].
//  Column:
//   - column[Y-1]=in_pixel; column[Y-2-k]=old lb[k][cx].
//   - Registered to out_column one cycle after acceptance (latency 1).
//  Window valid:
//   - win_ok = (rows_filled after update == Y-1).
//   - out_valid<=accepted && win_ok && not dropped; otherwise out_valid<=0.
//   - out_column holds its last value when out_valid=0.
//   - First frame output appears on line Y-1 (0-based); before that, out_valid stays 0.
//  Row reset:
//   - out_row_reset<=out_valid_next && cx==0.
//   - Asserted for exactly one cycle, coincident with the row's first valid column.
//  Peek:
//   - Shift register of WINDOW_SIZE_X columns, advanced only on out_valid columns and cleared on each row start.
//   - out_peek_column = entry emitted X valid columns ago.
//   - Reads 0 for the first X columns of a row (the downstream stage ignores peek during refill).
//  Idle: gaps (in_valid=0) between pixels change nothing except clearing out_valid/out_row_reset.
//  Simultaneous start flags: in_frame_start with in_line_start behaves as frame start.
//   - Start flags with in_valid=0 are ignored.
//  Reset mid-frame: all state returns to reset values; the next in_frame_start is required before out_valid rises.
//  Width rules: all pixel paths are unsigned LUMA_BITS; no arithmetic on data.
// TESTING  (LUMA_BITS=8, X=3, Y=3, IMAGE_WIDTH=8; pixel = 16*row+col)
//  Reset:
//   - Stimulus: reset_n=0 mid-stream.
//   - Required: all outputs 0 immediately (async).
//   - Required: after release and a new frame, out_valid stays 0 for rows 0-1.
//  Fill:
//   - Stimulus: frame of 4 rows x 8 px.
//   - Required: first out_valid at row 2 col 0 with out_column={0x00,0x10,0x20} and out_row_reset=1.
//   - Required: row 3 col 5 gives {0x15,0x25,0x35}.
//  Peek:
//   - Stimulus: row 2 cols 0-4.
//   - Required: out_peek_column=0 for cols 0-2.
//   - Required: col 3 peek={0x00,0x10,0x20}; col 4 peek={0x01,0x11,0x21}.
//  Gaps:
//   - Stimulus: random in_valid duty 50%.
//   - Required: same column sequence as back-to-back.
//   - Required: out_valid count = 8 per valid row; latency always 1 cycle.
//  Overrun:
//   - Stimulus: 10 px on one line.
//   - Required: px 8,9 dropped with no out_valid; out_overrun=1 and sticky until reset.
//  New frame:
//   - Stimulus: in_frame_start mid-line 3.
//   - Required: rows_filled resets; no out_valid until new row 2.
//   - Required: out_row_reset pulses once per valid row.

Source files
------------

// File: rtl/column_window_buffer.sv
// rtl/column_window_buffer.sv - line-buffered vertical column + peek column feeder
module column_window_buffer #(
    parameter int LUMA_BITS     = 8,
    parameter int WINDOW_SIZE_X = 31,
    parameter int WINDOW_SIZE_Y = 31,
    parameter int IMAGE_WIDTH   = 640
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     in_valid,
    input  logic                                     in_line_start,
    input  logic                                     in_frame_start,
    input  logic [LUMA_BITS-1:0]                     in_pixel,
    output logic                                     out_valid,
    output logic                                     out_row_reset,
    output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]  out_column,
    output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]  out_peek_column,
    output logic                                     out_overrun
);

    localparam int XW = $clog2(IMAGE_WIDTH + 1);
    localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = $clog2(WINDOW_SIZE_Y);
    localparam logic [RW-1:0] ROWS_FULL = RW'(WINDOW_SIZE_Y - 1);
    localparam logic [XW-1:0] X_LIMIT   = XW'(IMAGE_WIDTH);

    typedef logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] column_t;

    // Line buffers: index 0 holds the previous line, higher indices older lines.
    logic [LUMA_BITS-1:0] lb_mem [WINDOW_SIZE_Y-1][IMAGE_WIDTH];

    logic [XW-1:0] x_q, x_d;
    logic [RW-1:0] rows_q, rows_d;
    logic          frame_seen_q, frame_seen_d;
    logic          valid_q, valid_d;
    logic          row_reset_q, row_reset_d;
    logic          overrun_q, overrun_d;
    column_t       column_q, column_d;
    column_t       peek_q, peek_d;
    column_t       sr_q [WINDOW_SIZE_X];
    column_t       sr_d [WINDOW_SIZE_X];

    logic          start;
    logic          drop;
    logic          wr_en;
    logic [XW-1:0] cx;
    logic [AW-1:0] lb_addr;
    column_t       col_now;

    // Column counter, fill tracking, window assembly and peek shift register.
    always_comb begin
        x_d          = x_q;
        rows_d       = rows_q;
        frame_seen_d = frame_seen_q;
        overrun_d    = overrun_q;
        column_d     = column_q;
        peek_d       = peek_q;
        sr_d         = sr_q;

        start   = in_frame_start | in_line_start;
        cx      = start ? '0 : x_q;
        drop    = in_valid && !start && (x_q >= X_LIMIT);
        wr_en   = in_valid && !drop;
        lb_addr = AW'(cx);

        col_now[WINDOW_SIZE_Y-1] = in_pixel;
        for (int k = 0; k < WINDOW_SIZE_Y - 1; k++) begin
            col_now[WINDOW_SIZE_Y-2-k] = lb_mem[k][lb_addr];
        end

        if (in_valid) begin
            if (in_frame_start) begin
                x_d          = XW'(1);
                rows_d       = '0;
                frame_seen_d = 1'b1;
            end else if (in_line_start) begin
                x_d = XW'(1);
                // An empty previous line does not count as a completed row.
                if (x_q != '0 && rows_q != ROWS_FULL) begin
                    rows_d = rows_q + RW'(1);
                end
            end else if (!drop) begin
                x_d = x_q + XW'(1);
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Output is held off until a frame start has been seen since reset.
        valid_d     = wr_en && frame_seen_d && (rows_d == ROWS_FULL);
        row_reset_d = valid_d && (cx == '0);

        if (wr_en && cx == '0) begin
            for (int i = 0; i < WINDOW_SIZE_X; i++) begin
                sr_d[i] = '0;
            end
        end

        if (valid_d) begin
            column_d = col_now;
            peek_d   = (cx == '0) ? '0 : sr_q[WINDOW_SIZE_X-1];
            if (cx != '0) begin
                for (int i = WINDOW_SIZE_X - 1; i > 0; i--) begin
                    sr_d[i] = sr_q[i-1];
                end
            end
            sr_d[0] = col_now;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= '0;
            rows_q       <= '0;
            frame_seen_q <= 1'b0;
            valid_q      <= 1'b0;
            row_reset_q  <= 1'b0;
            overrun_q    <= 1'b0;
            column_q     <= '0;
            peek_q       <= '0;
            for (int i = 0; i < WINDOW_SIZE_X; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            x_q          <= x_d;
            rows_q       <= rows_d;
            frame_seen_q <= frame_seen_d;
            valid_q      <= valid_d;
            row_reset_q  <= row_reset_d;
            overrun_q    <= overrun_d;
            column_q     <= column_d;
            peek_q       <= peek_d;
            sr_q         <= sr_d;
        end
    end

    // Line-buffer cascade: each accepted pixel pushes the column down one line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb_mem[0][lb_addr] <= in_pixel;
            for (int k = 0; k < WINDOW_SIZE_Y - 2; k++) begin
                lb_mem[k+1][lb_addr] <= lb_mem[k][lb_addr];
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_row_reset   = row_reset_q;
    assign out_column      = column_q;
    assign out_peek_column = peek_q;
    assign out_overrun     = overrun_q;

endmodule
